// File: rtl/keccak_squeeze.sv
// Keccak-f[1600] squeeze reader: captures a permuted state, streams rate lanes as 64-bit words,
// and asks for extra permutations for long outputs. Optional macro KECCAK_SQUEEZE_BSWAP_EN byte-reverses words.
module keccak_squeeze #(
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          state_valid,
  output logic          state_ready,
  input  logic [1599:0] state_in,
  output logic [63:0]   dout_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          perm_req,
  output logic [1599:0] perm_state_out,
  input  logic          perm_done,
  input  logic [1599:0] perm_state_in,
  output logic          busy
);

  localparam int CNT_W = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OUT_LANES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [4:0]       LAST_LANE = 5'(RATE_LANES - 1);

  if (RATE_LANES < 1 || RATE_LANES > 25 || OUT_LANES < 1) begin : g_bad_param
    $fatal(1, "keccak_squeeze: RATE_LANES must be 1..25 and OUT_LANES >= 1");
  end

  typedef enum logic [1:0] {IDLE, EMIT, PERM} state_t;

  state_t           state_q;
  logic [1599:0]    st_q;
  logic [4:0]       lane_idx;
  logic [CNT_W-1:0] out_cnt;
  logic [1599:0]    st_sw;

  genvar gi, bi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_lane
`ifdef KECCAK_SQUEEZE_BSWAP_EN
      // byte 0 of each lane moves to the top byte for big-endian consumers
      for (bi = 0; bi < 8; bi++) begin : g_byte
        assign st_sw[64*gi + 8*bi +: 8] = st_q[64*gi + 8*(7-bi) +: 8];
      end
`else
      assign st_sw[64*gi +: 64] = st_q[64*gi +: 64];
`endif
    end
  endgenerate

  assign dout_data      = st_sw[{lane_idx, 6'd0} +: 64];
  assign perm_state_out = st_q;
  assign state_ready    = (state_q == IDLE) && !rst;
  assign busy           = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      st_q       <= '0;
      lane_idx   <= '0;
      out_cnt    <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      perm_req   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (state_valid) begin
            st_q       <= state_in;
            lane_idx   <= '0;
            out_cnt    <= '0;
            dout_valid <= 1'b1;
            dout_last  <= (LAST_CNT == '0);
            state_q    <= EMIT;
          end
        end
        EMIT: begin
          if (dout_ready) begin
            if (out_cnt == LAST_CNT) begin
              // last word wins over the rate boundary: no trailing permutation
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              state_q    <= IDLE;
            end else if (lane_idx == LAST_LANE) begin
              out_cnt    <= out_cnt + CNT_ONE;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              perm_req   <= 1'b1;
              state_q    <= PERM;
            end else begin
              lane_idx   <= lane_idx + 5'd1;
              out_cnt    <= out_cnt + CNT_ONE;
              dout_last  <= ((out_cnt + CNT_ONE) == LAST_CNT);
            end
          end
        end
        PERM: begin
          if (perm_done) begin
            st_q       <= perm_state_in;
            lane_idx   <= '0;
            perm_req   <= 1'b0;
            dout_valid <= 1'b1;
            dout_last  <= (out_cnt == LAST_CNT);
            state_q    <= EMIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: two instances (SHA3-256 4 words, SHAKE128-rate 25 words) against a block/lane model.
module tb_keccak_squeeze;

  localparam int RATEL [2] = '{17, 21};
  localparam int OUTL  [2] = '{4, 25};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          state_valid [2];
  logic          state_ready [2];
  logic [1599:0] state_in [2];
  logic [63:0]   dout_data [2];
  logic          dout_valid [2];
  logic          dout_ready [2];
  logic          dout_last [2];
  logic          perm_req [2];
  logic [1599:0] perm_state_out [2];
  logic          perm_done [2];
  logic [1599:0] perm_state_in [2];
  logic          busy [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keccak_squeeze #(.RATE_LANES(17), .OUT_LANES(4)) u_sha3 (
    .clk(clk), .rst(rst),
    .state_valid(state_valid[0]), .state_ready(state_ready[0]), .state_in(state_in[0]),
    .dout_data(dout_data[0]), .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]),
    .dout_last(dout_last[0]), .perm_req(perm_req[0]), .perm_state_out(perm_state_out[0]),
    .perm_done(perm_done[0]), .perm_state_in(perm_state_in[0]), .busy(busy[0])
  );

  keccak_squeeze #(.RATE_LANES(21), .OUT_LANES(25)) u_shake (
    .clk(clk), .rst(rst),
    .state_valid(state_valid[1]), .state_ready(state_ready[1]), .state_in(state_in[1]),
    .dout_data(dout_data[1]), .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]),
    .dout_last(dout_last[1]), .perm_req(perm_req[1]), .perm_state_out(perm_state_out[1]),
    .perm_done(perm_done[1]), .perm_state_in(perm_state_in[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Word k of a squeeze is lane (k mod rate) of block k/rate, optionally byte-reversed
  function automatic logic [63:0] model_word(input logic [1599:0] blk, input int lane);
    logic [63:0] w, r;
    w = blk[64*lane +: 64];
`ifdef KECCAK_SQUEEZE_BSWAP_EN
    for (int b = 0; b < 8; b++) r[8*(7-b) +: 8] = w[8*b +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic squeeze(input int d, input logic [1599:0] s, input int rmode,
                         input bit spur, input string nm, output int cyc);
    logic [1599:0] blk [$];
    logic [1599:0] pnew;
    int n, r, k, perms, reqc;
    bit rdy;
    n = OUTL[d]; r = RATEL[d];
    blk.push_back(s);
    check({nm, "/ready_idle"}, 64'(state_ready[d]), 64'd1);
    state_valid[d] = 1'b1; state_in[d] = s;
    @(negedge clk);
    state_valid[d] = 1'b0;
    check({nm, "/first_valid"}, 64'(dout_valid[d]), 64'd1);
    k = 0; perms = 0; cyc = 0; reqc = 0;
    while (k < n && cyc < 2000) begin
      state_valid[d] = 1'b0; perm_done[d] = 1'b0;
      if (dout_valid[d]) begin
        check({nm, $sformatf("/data%0d", k)}, dout_data[d], model_word(blk[k / r], k % r));
        check({nm, $sformatf("/last%0d", k)}, 64'(dout_last[d]), 64'(k == n - 1));
        check({nm, "/req_off_emit"}, 64'(perm_req[d]), 64'd0);
        check({nm, "/ready_busy"}, 64'(state_ready[d]), 64'd0);
        case (rmode)
          0: rdy = 1'b1;
          1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        dout_ready[d] = rdy;
        if (spur && $urandom_range(0, 2) == 0) begin
          state_valid[d] = 1'b1; state_in[d] = rand_state();
          perm_done[d] = 1'b1; perm_state_in[d] = rand_state();
        end
        if (rdy) k++;
      end else if (perm_req[d]) begin
        if (reqc == 0) begin
          perms++;
          for (int i = 0; i < 25; i++)
            check({nm, $sformatf("/pso_lane%0d", i)}, perm_state_out[d][64*i +: 64],
                  blk[blk.size() - 1][64*i +: 64]);
        end
        reqc++;
        if (reqc == 3) begin
          pnew = rand_state();
          perm_state_in[d] = pnew; perm_done[d] = 1'b1;
          blk.push_back(pnew);
          reqc = 0;
        end
      end else begin
        check({nm, "/active"}, 64'(dout_valid[d] | perm_req[d]), 64'd1);
      end
      cyc++;
      @(negedge clk);
    end
    state_valid[d] = 1'b0; perm_done[d] = 1'b0; dout_ready[d] = 1'b0;
    check({nm, "/word_count"}, 64'(k), 64'(n));
    check({nm, "/perm_count"}, 64'(perms), 64'((n + r - 1) / r - 1));
    check({nm, "/ready_after"}, 64'(state_ready[d]), 64'd1);
    check({nm, "/busy_after"}, 64'(busy[d]), 64'd0);
    check({nm, "/valid_after"}, 64'(dout_valid[d]), 64'd0);
    $display("squeeze %s: %0d words, %0d perms, %0d cycles", nm, k, perms, cyc);
  endtask

  initial begin
    logic [1599:0] s;
    int cyc, t;
    for (int d = 0; d < 2; d++) begin
      state_valid[d] = 1'b0; state_in[d] = '0; dout_ready[d] = 1'b0;
      perm_done[d] = 1'b0; perm_state_in[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d/state_ready", d), 64'(state_ready[d]), 64'd0);
      check($sformatf("rst%0d/dout_valid", d), 64'(dout_valid[d]), 64'd0);
      check($sformatf("rst%0d/dout_last", d), 64'(dout_last[d]), 64'd0);
      check($sformatf("rst%0d/perm_req", d), 64'(perm_req[d]), 64'd0);
      check($sformatf("rst%0d/busy", d), 64'(busy[d]), 64'd0);
      check($sformatf("rst%0d/dout_data", d), dout_data[d], 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) s[64*i +: 64] = 64'(i) * 64'h0101010101010101;
    squeeze(0, s, 0, 1'b0, "sha3_ramp", cyc);
    check("sha3_ramp/consecutive", 64'(cyc), 64'd4);

    s = rand_state();
    s[63:0] = 64'h0807060504030201;
    squeeze(0, s, 0, 1'b0, "sha3_bswap", cyc);

    squeeze(1, rand_state(), 0, 1'b0, "shake_long", cyc);
    squeeze(0, rand_state(), 1, 1'b0, "sha3_bp", cyc);
    squeeze(1, rand_state(), 1, 1'b0, "shake_bp", cyc);
    squeeze(0, rand_state(), 2, 1'b1, "sha3_spur", cyc);
    squeeze(1, rand_state(), 2, 1'b1, "shake_spur", cyc);

    // reset while the long squeeze waits on a permutation
    state_valid[1] = 1'b1; state_in[1] = rand_state();
    @(negedge clk);
    state_valid[1] = 1'b0; dout_ready[1] = 1'b1;
    t = 0;
    while (!perm_req[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rstperm/reached_perm", 64'(perm_req[1]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstperm/perm_req", 64'(perm_req[1]), 64'd0);
    check("rstperm/busy", 64'(busy[1]), 64'd0);
    check("rstperm/dout_valid", 64'(dout_valid[1]), 64'd0);
    check("rstperm/dout_last", 64'(dout_last[1]), 64'd0);
    check("rstperm/state_ready_in_rst", 64'(state_ready[1]), 64'd0);
    rst = 1'b0; dout_ready[1] = 1'b0;
    @(negedge clk);
    squeeze(1, rand_state(), 2, 1'b0, "shake_after_rst", cyc);

    for (int i = 0; i < 3; i++) begin
      squeeze(0, rand_state(), 2, 1'b1, $sformatf("sha3_rand%0d", i), cyc);
      squeeze(1, rand_state(), 2, 1'b1, $sformatf("shake_rand%0d", i), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
